// File: rtl/uart_pkg.sv
// Shared UART definitions: nominal timing constants, receiver state encoding
// and the parity helper shared by the receiver and the transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT = 13;
  localparam int SAMPLE_POINT = 6;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  // Parity bit that makes the frame match the selected sense (0 = even, 1 = odd).
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 parity_type);
    return (^data) ^ parity_type;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line and result signals of the UART receiver, bundled with
// modports for the receiver (slave) and whatever drives and observes it (master).
interface uart_rx_if;
  logic       rx;
  logic       parity_type;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_err;
  logic       framing_err;

  modport master (
    output rx, parity_type,
    input  rx_msg, rx_parity, rx_complete, parity_err, framing_err
  );

  modport slave (
    input  rx, parity_type,
    output rx_msg, rx_parity, rx_complete, parity_err, framing_err
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; resets to 1 so
// that reset never looks like a start bit.
module uart_sync2 (
  input  logic clk_3125,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits MSB first, parity, stop. Samples once per
// bit at a fixed offset from start detection and reports parity/framing errors.
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int SAMPLE_POINT = uart_pkg::SAMPLE_POINT
) (
  input  logic      clk_3125,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  import uart_pkg::*;

  localparam logic [3:0] LAST_CNT   = 4'(CLKS_PER_BIT - 1);
  localparam logic [3:0] SAMPLE_CNT = 4'(SAMPLE_POINT);
  localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);

  logic w_rx_s;

  rx_state_e r_state, w_state_next;
  logic [3:0] r_clk_cnt, w_clk_cnt_next;
  logic [3:0] r_bit_cnt, w_bit_cnt_next;
  logic [7:0] r_shift, w_shift_next;
  logic       r_par_bit, w_par_bit_next;
  logic       r_ptype, w_ptype_next;
  logic [7:0] r_msg, w_msg_next;
  logic       r_parity, w_parity_next;
  logic       r_complete, w_complete_next;
  logic       r_perr, w_perr_next;
  logic       r_ferr, w_ferr_next;

  uart_sync2 u_sync (
    .clk_3125 (clk_3125),
    .rst      (rst),
    .i_d      (bus.rx),
    .o_q      (w_rx_s)
  );

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_ptype    <= 1'b0;
      r_msg      <= '0;
      r_parity   <= 1'b0;
      r_complete <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clk_cnt  <= w_clk_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_par_bit  <= w_par_bit_next;
      r_ptype    <= w_ptype_next;
      r_msg      <= w_msg_next;
      r_parity   <= w_parity_next;
      r_complete <= w_complete_next;
      r_perr     <= w_perr_next;
      r_ferr     <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clk_cnt_next  = r_clk_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_par_bit_next  = r_par_bit;
    w_ptype_next    = r_ptype;
    w_msg_next      = r_msg;
    w_parity_next   = r_parity;
    w_complete_next = 1'b0;
    w_perr_next     = r_perr;
    w_ferr_next     = r_ferr;

    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_next   = START;
          w_clk_cnt_next = '0;
          w_bit_cnt_next = '0;
          w_ptype_next   = bus.parity_type;
        end
      end
      START: begin
        // A start bit that is already gone at mid-bit is treated as noise.
        if (r_clk_cnt == SAMPLE_CNT) begin
          w_clk_cnt_next = '0;
          w_state_next   = w_rx_s ? IDLE : DATA;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 4'd1;
        end
      end
      DATA: begin
        if (r_clk_cnt == LAST_CNT) begin
          w_shift_next   = {r_shift[6:0], w_rx_s};
          w_clk_cnt_next = '0;
          if (r_bit_cnt == LAST_BIT) begin
            w_bit_cnt_next = '0;
            w_state_next   = PARITY;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 4'd1;
        end
      end
      PARITY: begin
        if (r_clk_cnt == LAST_CNT) begin
          w_par_bit_next = w_rx_s;
          w_clk_cnt_next = '0;
          w_state_next   = STOP;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 4'd1;
        end
      end
      STOP: begin
        if (r_clk_cnt == LAST_CNT) begin
          w_msg_next      = r_shift;
          w_parity_next   = r_par_bit;
          w_perr_next     = (r_par_bit != calc_parity(r_shift, r_ptype));
          w_ferr_next     = ~w_rx_s;
          w_complete_next = 1'b1;
          w_clk_cnt_next  = '0;
          w_state_next    = w_rx_s ? IDLE : WAIT_HIGH;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 4'd1;
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must go high before another start is accepted.
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_clk_cnt_next = '0;
        w_bit_cnt_next = '0;
      end
    endcase
  end

  assign bus.rx_msg      = r_msg;
  assign bus.rx_parity   = r_parity;
  assign bus.rx_complete = r_complete;
  assign bus.parity_err  = r_perr;
  assign bus.framing_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: nominal frames, back-to-back reception, parity
// and framing errors, glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

  logic clk_3125 = 1'b0;
  logic rst      = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  int         pulse_cyc[$];
  logic [10:0] pulse_val[$];   // {rx_msg, rx_parity, parity_err, framing_err}

  uart_rx_if bus ();

  uart_rx dut (
    .clk_3125 (clk_3125),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_3125 = ~clk_3125;

  always @(posedge clk_3125) cyc = cyc + 1;

  always @(negedge clk_3125) begin
    if (bus.rx_complete === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back({bus.rx_msg, bus.rx_parity, bus.parity_err, bus.framing_err});
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_3125);
    #1;
  endtask

  // Drives one full frame starting right after a rising edge; t0 is the edge
  // count just before the first edge that samples the start bit.
  task automatic send_frame(input logic [7:0] data, input logic par,
                            input logic stop, output int t0);
    logic [10:0] frame;
    frame = {1'b0, data, par, stop};
    t0 = cyc;
    for (int i = 10; i >= 0; i--) begin
      bus.rx = frame[i];
      wait_cycles(13);
    end
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    bus.parity_type = 1'b0;
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.rx_msg !== 8'h00) begin n_errors++; $display("FAIL reset_msg: got %h expected 00", bus.rx_msg); end
    n_checks++;
    if ({bus.rx_parity, bus.parity_err, bus.framing_err, bus.rx_complete} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.rx_parity, bus.parity_err, bus.framing_err, bus.rx_complete});
    end
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(5);
    n_checks++;
    if (pulse_cyc.size() !== 0) begin n_errors++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", pulse_cyc.size()); end
    $display("reset: done");
  endtask

  task automatic test_even_a5();
    int t0;
    pulse_cyc.delete(); pulse_val.delete();
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    wait_cycles(5);
    n_checks++;
    if (pulse_cyc.size() !== 1) begin n_errors++; $display("FAIL a5_pulses: got %0d expected 1", pulse_cyc.size()); end
    n_checks++;
    if (pulse_cyc[0] !== t0 + 140) begin n_errors++; $display("FAIL a5_latency: got edge %0d expected 140", pulse_cyc[0] - t0); end
    n_checks++;
    if (pulse_val[0] !== {8'hA5, 1'b0, 1'b0, 1'b0}) begin n_errors++; $display("FAIL a5_result: got %h expected %h", pulse_val[0], {8'hA5, 3'b000}); end
    n_checks++;
    if (bus.rx_msg !== 8'hA5) begin n_errors++; $display("FAIL a5_hold: got %h expected a5", bus.rx_msg); end
    $display("frame a5 even: pulses=%0d msg=%h", pulse_cyc.size(), bus.rx_msg);
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    pulse_cyc.delete(); pulse_val.delete();
    bus.parity_type = 1'b1;
    fork
      begin
        send_frame(8'hA5, 1'b1, 1'b1, t0a);
        send_frame(8'h3C, 1'b1, 1'b1, t0b);
      end
      begin
        // Toggle parity_type inside each frame after it has been latched.
        wait_cycles(30);  bus.parity_type = 1'b0;
        wait_cycles(50);  bus.parity_type = 1'b1;
        wait_cycles(90);  bus.parity_type = 1'b0;
      end
    join
    wait_cycles(5);
    n_checks++;
    if (pulse_cyc.size() !== 2) begin n_errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulse_cyc.size()); end
    n_checks++;
    if (pulse_cyc[0] !== t0a + 140) begin n_errors++; $display("FAIL b2b_latency: got edge %0d expected 140", pulse_cyc[0] - t0a); end
    n_checks++;
    if (pulse_cyc[1] - pulse_cyc[0] !== 143) begin n_errors++; $display("FAIL b2b_spacing: got %0d expected 143", pulse_cyc[1] - pulse_cyc[0]); end
    n_checks++;
    if (pulse_val[0] !== {8'hA5, 1'b1, 1'b0, 1'b0}) begin n_errors++; $display("FAIL b2b_first: got %h expected %h", pulse_val[0], {8'hA5, 3'b100}); end
    n_checks++;
    if (pulse_val[1] !== {8'h3C, 1'b1, 1'b0, 1'b0}) begin n_errors++; $display("FAIL b2b_second: got %h expected %h", pulse_val[1], {8'h3C, 3'b100}); end
    bus.parity_type = 1'b0;
    $display("back-to-back odd a5/3c: pulses=%0d t0b-t0a=%0d", pulse_cyc.size(), t0b - t0a);
  endtask

  task automatic test_parity_err();
    int t0;
    pulse_cyc.delete(); pulse_val.delete();
    send_frame(8'h81, 1'b1, 1'b1, t0);
    wait_cycles(5);
    n_checks++;
    if (pulse_cyc.size() !== 1) begin n_errors++; $display("FAIL perr_pulses: got %0d expected 1", pulse_cyc.size()); end
    n_checks++;
    if (pulse_val[0] !== {8'h81, 1'b1, 1'b1, 1'b0}) begin n_errors++; $display("FAIL perr_result: got %h expected %h", pulse_val[0], {8'h81, 3'b110}); end
    n_checks++;
    if (bus.parity_err !== 1'b1) begin n_errors++; $display("FAIL perr_hold: got %b expected 1", bus.parity_err); end
    $display("frame 81 bad parity: parity_err=%b", bus.parity_err);
  endtask

  task automatic test_framing();
    int t0;
    pulse_cyc.delete(); pulse_val.delete();
    send_frame(8'h55, 1'b0, 1'b0, t0);
    wait_cycles(40);
    n_checks++;
    if (pulse_cyc.size() !== 1) begin n_errors++; $display("FAIL ferr_pulses_low: got %0d expected 1", pulse_cyc.size()); end
    bus.rx = 1'b1;
    wait_cycles(30);
    n_checks++;
    if (pulse_cyc.size() !== 1) begin n_errors++; $display("FAIL ferr_pulses_after: got %0d expected 1", pulse_cyc.size()); end
    n_checks++;
    if (pulse_cyc[0] !== t0 + 140) begin n_errors++; $display("FAIL ferr_latency: got edge %0d expected 140", pulse_cyc[0] - t0); end
    n_checks++;
    if (pulse_val[0] !== {8'h55, 1'b0, 1'b0, 1'b1}) begin n_errors++; $display("FAIL ferr_result: got %h expected %h", pulse_val[0], {8'h55, 3'b001}); end
    $display("frame 55 stop low: framing_err=%b pulses=%0d", bus.framing_err, pulse_cyc.size());
  endtask

  task automatic test_glitch();
    pulse_cyc.delete(); pulse_val.delete();
    bus.rx = 1'b0;
    wait_cycles(4);
    bus.rx = 1'b1;
    wait_cycles(200);
    n_checks++;
    if (pulse_cyc.size() !== 0) begin n_errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cyc.size()); end
    n_checks++;
    if (bus.rx_msg !== 8'h55) begin n_errors++; $display("FAIL glitch_msg: got %h expected 55", bus.rx_msg); end
    $display("glitch 4 cycles: pulses=%0d msg=%h", pulse_cyc.size(), bus.rx_msg);
  endtask

  task automatic test_reset_midframe();
    logic [3:0] head;
    int t0;
    pulse_cyc.delete(); pulse_val.delete();
    head = 4'b0101;   // start bit, then data bits 1..3 of 0xA5
    for (int i = 3; i >= 0; i--) begin
      bus.rx = head[i];
      wait_cycles(13);
    end
    bus.rx = 1'b0;     // data bit 4
    wait_cycles(6);
    rst = 1'b1;
    bus.rx = 1'b1;
    #2;
    n_checks++;
    if ({bus.rx_msg, bus.rx_parity, bus.parity_err, bus.framing_err, bus.rx_complete} !== 12'h000) begin
      n_errors++;
      $display("FAIL midrst_outputs: got %h expected 000",
               {bus.rx_msg, bus.rx_parity, bus.parity_err, bus.framing_err, bus.rx_complete});
    end
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(200);
    n_checks++;
    if (pulse_cyc.size() !== 0) begin n_errors++; $display("FAIL midrst_pulses: got %0d expected 0", pulse_cyc.size()); end
    send_frame(8'hF0, 1'b0, 1'b1, t0);
    wait_cycles(5);
    n_checks++;
    if (pulse_cyc.size() !== 1) begin n_errors++; $display("FAIL f0_pulses: got %0d expected 1", pulse_cyc.size()); end
    n_checks++;
    if (pulse_cyc[0] !== t0 + 140) begin n_errors++; $display("FAIL f0_latency: got edge %0d expected 140", pulse_cyc[0] - t0); end
    n_checks++;
    if (pulse_val[0] !== {8'hF0, 1'b0, 1'b0, 1'b0}) begin n_errors++; $display("FAIL f0_result: got %h expected %h", pulse_val[0], {8'hF0, 3'b000}); end
    $display("reset mid-frame then f0: msg=%h pulses=%0d", bus.rx_msg, pulse_cyc.size());
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.parity_type = 1'b0;
    test_reset();
    test_even_a5();
    test_back_to_back();
    test_parity_err();
    test_framing();
    test_glitch();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
